// File: rtl/uart_hex_word_tx.sv
// uart_hex_word_tx
// Accepts a 32-bit word over a valid/ready handshake and sends it on a UART
// TX line (8N1) as eight uppercase ASCII hex characters, most significant
// nibble first, optionally followed by CR LF. Carries its own baud counter
// and serialiser.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   word_in     word to send, sampled only when accepted
//   word_valid  word_in is valid
//   word_ready  idle and able to accept a word (registered)
//   tx          UART serial out, idles high (registered)
//   busy        inverse of word_ready
//   done        one-cycle pulse after the last stop bit of a word (registered)
module uart_hex_word_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter bit SEND_CRLF    = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int N_CHARS = SEND_CRLF ? 10 : 8;
  localparam int BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [3:0]        CHAR_LAST = 4'(N_CHARS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    logic [7:0] r;
    if (n < 4'd10) begin
      r = 8'h30 + {4'h0, n};
    end else begin
      r = 8'h41 + ({4'h0, n} - 8'd10);
    end
    return r;
  endfunction

  // Byte sent at character position idx of the word.
  function automatic logic [7:0] char_at(input logic [31:0] w, input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = hex_ascii(w[31:28]);
      4'd1:    r = hex_ascii(w[27:24]);
      4'd2:    r = hex_ascii(w[23:20]);
      4'd3:    r = hex_ascii(w[19:16]);
      4'd4:    r = hex_ascii(w[15:12]);
      4'd5:    r = hex_ascii(w[11:8]);
      4'd6:    r = hex_ascii(w[7:4]);
      4'd7:    r = hex_ascii(w[3:0]);
      4'd8:    r = 8'h0D;
      4'd9:    r = 8'h0A;
      default: r = 8'hFF;
    endcase
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [3:0]          char_q, char_d;
  logic [31:0]         word_q, word_d;
  logic                tx_q, tx_d;
  logic                done_q, done_d;
  logic                ready_q, ready_d;
  logic [7:0]          char_byte;
  logic                baud_end;

  // Next-state logic: the tx level is computed one cycle ahead so that the
  // line itself comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    char_d    = char_q;
    word_d    = word_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    ready_d   = ready_q;
    char_byte = char_at(word_q, char_q);
    baud_end  = (baud_q == BAUD_LAST);

    case (state_q)
      S_IDLE: begin
        if (word_valid && ready_q) begin
          word_d  = word_in;
          state_d = S_START;
          baud_d  = '0;
          bit_d   = 3'd0;
          char_d  = 4'd0;
          tx_d    = 1'b0;
          ready_d = 1'b0;
        end else begin
          tx_d    = 1'b1;
          ready_d = 1'b1;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
          tx_d    = char_byte[0];
        end else begin
          baud_d  = baud_q + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = char_byte[bit_q + 3'd1];
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (char_q == CHAR_LAST) begin
            // Last frame of the word: return to idle and announce completion.
            state_d = S_IDLE;
            tx_d    = 1'b1;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            // Next character starts immediately, no idle gap.
            char_d  = char_q + 4'd1;
            state_d = S_START;
            tx_d    = 1'b0;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset forces the line high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      char_q  <= 4'd0;
      word_q  <= 32'd0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      char_q  <= char_d;
      word_q  <= word_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign tx         = tx_q;
  assign done       = done_q;
  assign word_ready = ready_q;
  assign busy       = ~ready_q;

endmodule

// File: doc/uart_hex_word_tx.md
Name: uart_hex_word_tx

Overview:
Transmit-side companion to the UART hex loader. Takes a 32-bit word from the CPU side, e.g. a register or data-memory value, through a valid/ready handshake. Serialises it on a UART TX line as 8 uppercase ASCII hex characters, MSB nibble first, optionally followed by CR LF. Contains its own baud counter and 8N1 serialiser, so it does not depend on the shared uart block's TX path.

Parameters:
- CLKS_PER_BIT, 434: clock cycles per UART bit (50 MHz / 115200); legal range ≥ 2.
- SEND_CRLF, 1: 1 appends 0x0D, 0x0A after the 8 hex chars; 0 sends hex chars only.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- word_in, input, 32: word to transmit; sampled on acceptance only.
- word_valid, input, 1: word_in is valid.
- word_ready, output, 1: block idle and able to accept a word.
- tx, output, 1: UART serial out, idle high, registered.
- busy, output, 1: equals !word_ready.
- done, output, 1: one-cycle pulse when the final stop bit of a word completes.

Behaviour:
- Clock and reset: single clock domain clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - tx=1, word_ready=1, busy=0, done=0.
  - State IDLE; char index 0; bit counter 0; baud counter 0.
- Acceptance: a word is accepted on a rising edge where word_valid && word_ready.
  - word_in is latched into a shift register.
  - word_ready drops in the next cycle.
  - word_valid while not ready is ignored: not latched, no queueing.
- Character sequence:
  - Index 0..7 carries nibble [31-4k : 28-4k].
  - Index 8 = 0x0D and index 9 = 0x0A, only if SEND_CRLF=1.
  - N_CHARS = 10 or 8.
- Hex encoding: n in 0..9 maps to 8'h30+n; n in 10..15 maps to 8'h41+(n-10). Uppercase only, to match the loader's accepted set.
- State machine: IDLE -> START -> DATA -> STOP -> (START for next char | IDLE).
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles; bit counter 0..7.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - After STOP: if char index < N_CHARS-1, increment the index and go to START with no idle gap. Otherwise go to IDLE.
- Timing:
  - tx first goes low in the cycle after acceptance.
  - Each frame lasts exactly 10*CLKS_PER_BIT cycles; a word lasts N_CHARS*10*CLKS_PER_BIT cycles.
  - In the cycle after the last stop bit ends: done=1, word_ready=1, tx=1.
- Back-to-back words: a word_valid already high while done=1 is accepted on that same edge, because word_ready=1 in that cycle. The next start bit then begins the following cycle, giving one idle-high cycle between words.
- Baud counter: counts 0..CLKS_PER_BIT-1, reloads at each bit boundary, and is cleared on acceptance. It is sized $clog2(CLKS_PER_BIT).
- Reset mid-operation: tx goes high immediately (asynchronous), state returns to IDLE, the in-flight word is dropped, and no done pulse is produced.
- tx, done and word_ready are driven from flops; there is no combinational path from word_valid to any output.

Test Plan:
1. CLKS_PER_BIT=4, SEND_CRLF=1, word_in=32'h1234ABCD, one-cycle valid -> tx decodes 0x31 0x32 0x33 0x34 0x41 0x42 0x43 0x44 0x0D 0x0A. busy is high for exactly 400 cycles, and done pulses once, in the first cycle after those 400.
2. SEND_CRLF=0, word_in=32'h00000000 -> eight 0x30 chars; busy high 320 cycles. For char 0 the tx bits are 0 (start), 0,0,0,0,1,1,0,0 (LSB first), then 1 (stop), 4 cycles each.
3. word_in=32'hFFFFFFFF -> eight 0x46 chars then CR LF. Check that no gap cycles appear between consecutive frames.
4. Accept 32'h00000001, then hold word_valid=1 with word_in=32'hDEADBEEF throughout the first transmission -> the second word is not accepted until the done cycle. Its output is "DEADBEEF\r\n"; exactly one idle-high cycle separates the two words.
5. Assert rst_n=0 mid-DATA of char 3 -> tx=1 within the same cycle, word_ready=1, busy=0, no done. A new word after reset is transmitted correctly from char 0.
6. Loopback: tx feeds the team's uart receiver at matching baud, for 16 random words -> the received byte stream equals the expected hex/CRLF string for every word.
